// File: rtl/sys_ctrl_if.sv
// sys_ctrl_if: bundles the UART RX/TX, register-file and ALU signals of sys_ctrl.
// master is the controller side, slave is the surrounding peripherals.
interface sys_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic                     WrEn;
  logic                     RdEn;
  logic [ADDR_WIDTH-1:0]    Address;
  logic [DATA_WIDTH-1:0]    WrData;
  logic [DATA_WIDTH-1:0]    RdData;
  logic                     ALU_EN;
  logic [3:0]               ALU_FUN;
  logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
  logic                     ALU_VLD;
  logic                     CLK_EN;
  logic [DATA_WIDTH-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     TX_BUSY;
  logic                     ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, ALU_OUT, ALU_VLD, TX_BUSY,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN,
           TX_P_DATA, TX_D_VLD, ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, ALU_OUT, ALU_VLD, TX_BUSY,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN,
           TX_P_DATA, TX_D_VLD, ERR
  );
endinterface

// File: rtl/sys_ctrl.sv
// sys_ctrl: turns UART command frames into register-file writes/reads and ALU runs, returning results over TX.
// Defining SYS_CTRL_TIMEOUT_EN adds an inter-byte timeout that abandons stalled frames.
module sys_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          CLK,
  input  logic          RST,
  sys_ctrl_if.master    bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_CAP,
    OP_A,
    OP_B,
    ALU_FUN,
    ALU_WAIT,
    TX_SEND,
    TX_ACK
  } state_t;

  state_t                   state_q, state_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     alu_en_q, alu_en_d;
  logic [3:0]               alu_fun_q, alu_fun_d;
  logic                     clk_en_q, clk_en_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     tx_vld_q, tx_vld_d;
  logic                     err_q, err_d;
  logic [ALU_OUT_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                     tx_more_q, tx_more_d;
  logic                     seen_busy_q, seen_busy_d;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    alu_en_d    = 1'b0;
    alu_fun_d   = alu_fun_q;
    clk_en_d    = clk_en_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = 1'b0;
    err_d       = 1'b0;
    tx_buf_d    = tx_buf_q;
    tx_more_d   = tx_more_q;
    seen_busy_d = seen_busy_q;

    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_WR)          state_d = WR_ADDR;
          else if (bus.RX_P_DATA == CMD_RD)     state_d = RD_ADDR;
          else if (bus.RX_P_DATA == CMD_ALU_OP) state_d = OP_A;
          else if (bus.RX_P_DATA == CMD_ALU)    state_d = ALU_FUN;
          else                                  err_d   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wr_data_d = bus.RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = RD_CAP;
        end
      end
      RD_CAP: begin
        if (bus.RX_D_VLD) err_d = 1'b1;
        // RdData is only valid once the RdEn cycle has passed; send it straight out if TX is free.
        if (!rd_en_q) begin
          tx_buf_d  = ALU_OUT_WIDTH'(bus.RdData);
          tx_more_d = 1'b0;
          if (!bus.TX_BUSY) begin
            tx_data_d   = bus.RdData;
            tx_vld_d    = 1'b1;
            seen_busy_d = 1'b0;
            state_d     = TX_ACK;
          end else begin
            state_d = TX_SEND;
          end
        end
      end
      OP_A: begin
        if (bus.RX_D_VLD) begin
          addr_d    = '0;
          wr_data_d = bus.RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = OP_B;
        end
      end
      OP_B: begin
        if (bus.RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(1);
          wr_data_d = bus.RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (bus.RX_D_VLD) begin
          alu_fun_d = bus.RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.RX_D_VLD) err_d = 1'b1;
        if (bus.ALU_VLD) begin
          tx_buf_d  = bus.ALU_OUT;
          tx_more_d = 1'b1;
          clk_en_d  = 1'b0;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (bus.RX_D_VLD) err_d = 1'b1;
        if (!bus.TX_BUSY) begin
          tx_data_d   = tx_buf_q[DATA_WIDTH-1:0];
          tx_vld_d    = 1'b1;
          tx_buf_d    = tx_buf_q >> DATA_WIDTH;
          seen_busy_d = 1'b0;
          state_d     = TX_ACK;
        end
      end
      TX_ACK: begin
        if (bus.RX_D_VLD) err_d = 1'b1;
        // A byte counts as sent only after the transmitter has gone busy and then idle again.
        if (bus.TX_BUSY) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          seen_busy_d = 1'b0;
          if (tx_more_q) begin
            tx_more_d = 1'b0;
            state_d   = TX_SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    timer_d = '0;
    if (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN, ALU_WAIT}) begin
      if (bus.RX_D_VLD && state_q != ALU_WAIT) begin
        timer_d = '0;
      end else if (state_q == ALU_WAIT && bus.ALU_VLD) begin
        timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
        state_d  = IDLE;
        err_d    = 1'b1;
        clk_en_d = 1'b0;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      clk_en_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      err_q       <= 1'b0;
      tx_buf_q    <= '0;
      tx_more_q   <= 1'b0;
      seen_busy_q <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      clk_en_q    <= clk_en_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      err_q       <= err_d;
      tx_buf_q    <= tx_buf_d;
      tx_more_q   <= tx_more_d;
      seen_busy_q <= seen_busy_d;
`ifdef SYS_CTRL_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wr_data_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.CLK_EN    = clk_en_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.ERR       = err_q;

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

System controller that parses command frames arriving byte-by-byte from the UART receiver and converts them into register-file write/read transactions and ALU operations. It sits directly upstream of the 16x8 register file: it drives the register file's write-enable, read-enable, address and write-data inputs, and consumes its read data. ALU and register-read results are returned to the UART transmitter as byte streams.

## Interface
- DATA_WIDTH, 8, register-file data width and UART byte width
- ADDR_WIDTH, 4, register-file address width
- ALU_OUT_WIDTH, 16, ALU result width; always returned as two bytes
- TIMEOUT_CYCLES, 4096, inter-byte timeout; used only when SYS_CTRL_TIMEOUT_EN is defined
- CLK  in  1  single system clock; all logic is on the rising edge
- RST  in  1  asynchronous reset, active-high
- RX_P_DATA  in  8  received byte
- RX_D_VLD  in  1  one-cycle pulse marking RX_P_DATA valid
- WrEn  out  1  register-file write enable, one-cycle pulse
- RdEn  out  1  register-file read enable, one-cycle pulse
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- RdData  in  DATA_WIDTH  register-file read data; valid the cycle after RdEn
- ALU_EN  out  1  ALU start, one-cycle pulse
- ALU_FUN  out  4  ALU function code, held from ALU_EN until ALU_VLD
- ALU_OUT  in  16  ALU result
- ALU_VLD  in  1  ALU result valid, one-cycle pulse
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  8  byte to transmit
- TX_D_VLD  out  1  one-cycle pulse requesting transmission of TX_P_DATA
- TX_BUSY  in  1  transmitter busy
- ERR  out  1  one-cycle pulse on a protocol error

## Operation
- Frames (first byte = command):
  - 0xAA, addr, data: register write.
  - 0xBB, addr: register read; returns 1 byte.
  - 0xCC, A, B, fun: write A to address 0 and B to address 1, then run ALU; returns 2 bytes.
  - 0xDD, fun: run ALU on the stored operands; returns 2 bytes.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CAP, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_SEND, TX_ACK.
- Only addr[ADDR_WIDTH-1:0] is used; upper address bits are ignored. fun uses bits [3:0] only.
- Never asserts WrEn and RdEn in the same cycle.
- ALU results are transmitted LSB byte first, then MSB byte.
- Errors:
  - An unknown command byte in IDLE pulses ERR and the FSM stays in IDLE.
  - A byte arriving in RD_CAP, ALU_WAIT, TX_SEND or TX_ACK is dropped and ERR pulses.
- Reset values: all outputs 0; FSM in IDLE; result buffers cleared.

## Timing
- All outputs are registered.
- Register write:
  - Data-byte RX_D_VLD at cycle n → WrEn=1 at n+1, with Address and WrData valid.
  - Operands A and B each produce the same one-cycle WrEn pulse, at addresses 0 and 1.
- Register read:
  - Addr-byte RX_D_VLD at n → RdEn=1 with Address at n+1.
  - RdData is sampled at n+2 (RD_CAP).
  - Earliest TX_D_VLD is at n+3.
- ALU:
  - Fun byte at n → ALU_EN=1 and CLK_EN=1 at n+1.
  - CLK_EN stays high through the cycle in which ALU_VLD is sampled, then drops.
  - ALU_OUT is captured on ALU_VLD.
- TX handshake:
  - TX_SEND pulses TX_D_VLD for one cycle only when TX_BUSY=0.
  - TX_ACK waits for TX_BUSY=1, then TX_BUSY=0, before the next byte or before returning to IDLE.
  - TX_P_DATA is held stable from TX_D_VLD until TX_BUSY falls.
- Back-to-back frames are accepted: a command byte arriving in the cycle after a write frame completes is decoded normally.
- Reset mid-frame clears the partial frame; any pending TX bytes are discarded.

## Configuration
- Macro: SYS_CTRL_TIMEOUT_EN.
- Defined:
  - A counter restarts on every RX_D_VLD while in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B or ALU_FUN.
  - It also runs in ALU_WAIT.
  - When TIMEOUT_CYCLES elapse, the FSM returns to IDLE, pulses ERR and deasserts CLK_EN.
- Undefined: no counter; partial frames wait indefinitely.

## Test plan
- Write: bytes 0xAA, 0x05, 0x3C → exactly one WrEn pulse with Address=5 and WrData=0x3C; no TX_D_VLD.
- Read with backpressure:
  - Setup: register 5 = 0x3C; hold TX_BUSY=1; send 0xBB, 0x05.
  - Expect: RdEn pulse with Address=5; no TX_D_VLD until TX_BUSY=0; then one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands:
  - Send 0xCC, 0x12, 0x34, 0x00.
  - Expect WrEn at address 0 (0x12) and at address 1 (0x34); ALU_EN with ALU_FUN=0; CLK_EN high until ALU_VLD.
  - With ALU_OUT=0x0046: TX bytes 0x46, then 0x00.
- Errors:
  - Byte 0x77 in IDLE → ERR pulse; next frame 0xDD, 0x01 processes normally.
  - Byte sent during ALU_WAIT → ERR pulse; ALU result still transmitted.
- Reset: assert RST after 0xAA, 0x03 → all outputs 0; following 0x44 byte is an unknown command (ERR pulse), not write data.
- Timeout (SYS_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): send 0xAA then idle 16 cycles → ERR pulse, FSM in IDLE, no WrEn.
